// File: rtl/ringvco_meas_pkg.sv
// Shared types and defaults for the ring-VCO frequency counter.
package ringvco_meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_HOLD    = 2'd3
    } meas_state_e;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned WIN_W_DEF = 16;

    // One extra cycle past the synchronizer depth also flushes the edge-detect flop.
    function automatic int unsigned settle_len(input int unsigned sync_stages);
        return sync_stages + 1;
    endfunction

endpackage

// File: rtl/ringvco_freq_counter_if.sv
// Control/result handshake between the scan logic (master) and the counter (slave).
interface ringvco_freq_counter_if
    import ringvco_meas_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned WIN_W = WIN_W_DEF
) ();

    logic             start;
    logic             cont;
    logic [WIN_W-1:0] win_len;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic             count_valid;
    logic             count_ready;
    logic             overflow;

    modport master (
        output start, cont, win_len, count_ready,
        input  busy, count, count_valid, overflow
    );

    modport slave (
        input  start, cont, win_len, count_ready,
        output busy, count, count_valid, overflow
    );

endinterface

// File: rtl/ringvco_sync_edge.sv
// Multi-flop synchronizer for the asynchronous VCO output plus rising-edge detect.
module ringvco_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
            s_d_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] & ~s_d_q;

endmodule

// File: rtl/ringvco_freq_counter.sv
// Gated rising-edge counter for the ring VCO with a valid/ready result port.
module ringvco_freq_counter
    import ringvco_meas_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned WIN_W       = WIN_W_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   vco_in,
    ringvco_freq_counter_if.slave  bus
);

    localparam int unsigned SETTLE_LEN = settle_len(SYNC_STAGES);
    localparam int unsigned SET_W      = $clog2(SETTLE_LEN + 1);

    meas_state_e      state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [WIN_W-1:0] wcnt_q, wcnt_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             vco_edge;

    ringvco_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_async(vco_in),
        .edge_o (vco_edge)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            win_q    <= '0;
            wcnt_q   <= '0;
            settle_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            wcnt_q   <= wcnt_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        wcnt_d   = wcnt_q;
        settle_d = settle_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;

        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        win_d    = bus.win_len;
                        cnt_d    = '0;
                        ovf_d    = 1'b0;
                        settle_d = SET_W'(SETTLE_LEN - 1);
                        state_d  = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == '0) begin
                        if (win_q == '0) begin
                            state_d = ST_HOLD;
                        end else begin
                            wcnt_d  = win_q;
                            state_d = ST_MEASURE;
                        end
                    end else begin
                        settle_d = settle_q - SET_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (vco_edge) begin
                        if (cnt_q == '1) ovf_d = 1'b1;
                        else             cnt_d = cnt_q + CNT_W'(1);
                    end
                    // Window counter stops at 1 so it never wraps through zero.
                    if (wcnt_q == WIN_W'(1)) state_d = ST_HOLD;
                    else                     wcnt_d  = wcnt_q - WIN_W'(1);
                end
                ST_HOLD: begin
                    if (bus.count_ready) begin
                        if (bus.cont) begin
                            win_d    = bus.win_len;
                            cnt_d    = '0;
                            ovf_d    = 1'b0;
                            settle_d = SET_W'(SETTLE_LEN - 1);
                            state_d  = ST_SETTLE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.count_valid = (state_q == ST_HOLD);
    assign bus.count       = cnt_q;
    assign bus.overflow    = ovf_q;

endmodule
